// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller wrapped around a combinational ALU; owns the architectural EX register.
// Latency: accept edge N -> wb_valid after edge N+1, plus MULDIV_LAT cycles for MUL..MDI (0x04-0x09).
// Backpressure: wb_* hold until wb_ready; in_ready = IDLE | (WB & wb_ready), so ops can go back-to-back.
//
// Ports:
//   clk, rst_n                       clock (rising edge), async active-low reset
//   in_valid/in_ready, in_op/b/a     decoded op handshake and operands
//   alu_op/b/a/exin -> ALU           operands held from capture; alu_exin is the live EX register
//   alu_q/exout/cl/eq/lt/un <- ALU   combinational ALU results and condition flags
//   wb_valid/wb_ready, wb_q/en/skip/ill   registered writeback result and handshake
//   ex_set_valid/ex_set_data         direct EX write (SET EX,x), wins over a same-cycle commit
//   ex                               current EX register
module alu_issue_ctrl #(
  parameter int unsigned MULDIV_LAT = 2,
  parameter logic [15:0] EX_RESET   = 16'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_op,
  input  logic [15:0] in_b,
  input  logic [15:0] in_a,
  output logic [4:0]  alu_op,
  output logic [15:0] alu_b,
  output logic [15:0] alu_a,
  output logic [15:0] alu_exin,
  input  logic [15:0] alu_q,
  input  logic [15:0] alu_exout,
  input  logic        alu_cl,
  input  logic        alu_eq,
  input  logic        alu_lt,
  input  logic        alu_un,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [15:0] wb_q,
  output logic        wb_en,
  output logic        wb_skip,
  output logic        wb_ill,
  input  logic        ex_set_valid,
  input  logic [15:0] ex_set_data,
  output logic [15:0] ex
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  localparam logic [3:0] LAT_CNT = 4'(MULDIV_LAT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_op;
  logic [15:0] r_b;
  logic [15:0] r_a;
  logic [3:0]  r_cnt;
  logic [15:0] r_ex;
  logic [15:0] r_exout;
  logic        r_commit;
  logic [15:0] r_wb_q;
  logic        r_wb_en;
  logic        r_wb_skip;
  logic        r_wb_ill;

  logic        w_capture;
  logic        w_wb_load;
  logic        w_hs;
  logic        w_cond;
  logic        w_is_if;
  logic        w_is_ill;
  logic        w_commits;

  function automatic logic f_is_muldiv(input logic [4:0] op);
    return (op >= 5'h04) && (op <= 5'h09);
  endfunction

  // Op classification for the op held in EXEC.
  always_comb begin
    w_is_if   = (r_op >= 5'h10) && (r_op <= 5'h17);
    w_is_ill  = (r_op <= 5'h01) || (r_op == 5'h18) || (r_op == 5'h19) || (r_op >= 5'h1C);
    w_commits = 1'b0;
    case (r_op)
      5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
      5'h0D, 5'h0E, 5'h0F, 5'h1A, 5'h1B: w_commits = 1'b1;
      default:                           w_commits = 1'b0;
    endcase
  end

  // IF condition true means "execute next"; wb_skip is its inverse.
  always_comb begin
    w_cond = 1'b0;
    case (r_op)
      5'h10:   w_cond = !alu_cl;
      5'h11:   w_cond = alu_cl;
      5'h12:   w_cond = alu_eq;
      5'h13:   w_cond = !alu_eq;
      5'h14:   w_cond = !alu_eq && !alu_lt;
      5'h15:   w_cond = !alu_eq && !alu_un;
      5'h16:   w_cond = alu_lt;
      5'h17:   w_cond = alu_un;
      default: w_cond = 1'b0;
    endcase
  end

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_wb_load   = 1'b0;
    w_hs        = 1'b0;
    in_ready    = 1'b0;
    wb_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_cnt == 4'd0) begin
          w_wb_load   = 1'b1;
          w_state_nxt = S_WB;
        end
      end
      S_WB: begin
        wb_valid = 1'b1;
        in_ready = wb_ready;
        if (wb_ready) begin
          w_hs = 1'b1;
          if (in_valid) begin
            w_capture   = 1'b1;
            w_state_nxt = S_EXEC;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture and multi-cycle countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= 5'h0;
      r_b   <= 16'h0;
      r_a   <= 16'h0;
      r_cnt <= 4'd0;
    end else if (w_capture) begin
      r_op  <= in_op;
      r_b   <= in_b;
      r_a   <= in_a;
      r_cnt <= f_is_muldiv(in_op) ? LAT_CNT : 4'd0;
    end else if (r_state == S_EXEC && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Writeback registers; loaded once at the end of EXEC, so they stay stable through WB.
  // The ALU's EX result is parked here and only committed on the writeback handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_q    <= 16'h0;
      r_wb_en   <= 1'b0;
      r_wb_skip <= 1'b0;
      r_wb_ill  <= 1'b0;
      r_exout   <= 16'h0;
      r_commit  <= 1'b0;
    end else if (w_wb_load) begin
      r_wb_q    <= alu_q;
      r_wb_en   <= !w_is_ill && !w_is_if;
      r_wb_skip <= w_is_if && !w_cond;
      r_wb_ill  <= w_is_ill;
      r_exout   <= alu_exout;
      r_commit  <= w_commits;
    end
  end

  // A direct EX write is later in program order than the op being retired, so it wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex <= EX_RESET;
    end else if (ex_set_valid) begin
      r_ex <= ex_set_data;
    end else if (w_hs && r_commit) begin
      r_ex <= r_exout;
    end
  end

  assign alu_op   = r_op;
  assign alu_b    = r_b;
  assign alu_a    = r_a;
  assign alu_exin = r_ex;
  assign ex       = r_ex;
  assign wb_q     = r_wb_q;
  assign wb_en    = r_wb_en;
  assign wb_skip  = r_wb_skip;
  assign wb_ill   = r_wb_ill;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a behavioural ALU attached; expected writebacks come from a
// constant table pushed into a scoreboard and popped on each wb handshake.
// Latency, wb hold stability, EX/ex_set priority and mid-op reset are covered by hand sequences.
module tb_alu_issue_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_op = 5'h0;
  logic [15:0] in_b = 16'h0;
  logic [15:0] in_a = 16'h0;
  logic [4:0]  alu_op;
  logic [15:0] alu_b, alu_a, alu_exin;
  logic [15:0] alu_q, alu_exout;
  logic        alu_cl, alu_eq, alu_lt, alu_un;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [15:0] wb_q;
  logic        wb_en, wb_skip, wb_ill;
  logic        ex_set_valid = 1'b0;
  logic [15:0] ex_set_data = 16'h0;
  logic [15:0] ex;

  alu_issue_ctrl #(.MULDIV_LAT(LAT), .EX_RESET(16'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_b(in_b), .in_a(in_a),
    .alu_op(alu_op), .alu_b(alu_b), .alu_a(alu_a), .alu_exin(alu_exin),
    .alu_q(alu_q), .alu_exout(alu_exout),
    .alu_cl(alu_cl), .alu_eq(alu_eq), .alu_lt(alu_lt), .alu_un(alu_un),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_q(wb_q), .wb_en(wb_en),
    .wb_skip(wb_skip), .wb_ill(wb_ill),
    .ex_set_valid(ex_set_valid), .ex_set_data(ex_set_data), .ex(ex)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: only the ops used by the vectors below.
  logic [31:0] t_r;
  logic [31:0] t_d;
  always_comb begin
    t_r       = 32'h0;
    t_d       = 32'h0;
    alu_q     = 16'h0;
    alu_exout = 16'h0;
    case (alu_op)
      5'h02: t_r = {16'h0, alu_b} + {16'h0, alu_a};
      5'h03: t_r = {16'h0, alu_b} - {16'h0, alu_a};
      5'h04: t_r = {16'h0, alu_b} * {16'h0, alu_a};
      5'h06: if (alu_a != 16'h0) begin
               t_d = {alu_b, 16'h0} / {16'h0, alu_a};
               t_r = {t_d[15:0], alu_b / alu_a};
             end
      5'h08: if (alu_a != 16'h0) t_r = {16'h0, alu_b % alu_a};
      5'h0A: t_r = {16'h0, alu_b & alu_a};
      5'h0F: t_r = {16'h0, alu_b} << alu_a[3:0];
      5'h1A: t_r = {16'h0, alu_b} + {16'h0, alu_a} + {16'h0, alu_exin};
      default: t_r = 32'h0;
    endcase
    alu_q     = t_r[15:0];
    alu_exout = t_r[31:16];
  end
  assign alu_cl = ((alu_b & alu_a) == 16'h0);
  assign alu_eq = (alu_b == alu_a);
  assign alu_lt = (alu_b < alu_a);
  assign alu_un = ($signed(alu_b) < $signed(alu_a));

  typedef struct {
    logic [4:0]  op;
    logic [15:0] b;
    logic [15:0] a;
    logic [15:0] q;
    logic        chk_q;
    logic        en;
    logic        skip;
    logic        ill;
    logic [15:0] ex;
    logic        chk_exin;
    logic [15:0] exin;
    int          lat;
  } vec_t;

  vec_t sb[$];
  int   acc_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor at negedge: latency on wb_valid rise, hold stability, result on handshake,
  // and EX one cycle after the handshake.
  logic        prev_vld = 1'b0;
  logic        hold_set = 1'b0;
  logic [18:0] hold_val;
  logic        ex_pend = 1'b0;
  logic [15:0] ex_exp;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld = 1'b0;
      hold_set = 1'b0;
      ex_pend  = 1'b0;
    end else begin
      if (ex_pend) begin
        check("ex_after_commit", 32'(ex), 32'(ex_exp));
        ex_pend = 1'b0;
      end
      if (wb_valid && !prev_vld) begin
        if (acc_q.size() != 0 && sb.size() != 0) begin
          check("wb_latency", 32'(cyc - acc_q.pop_front()), 32'(sb[0].lat));
        end else begin
          check("wb_unexpected", 32'(wb_valid), 32'h0);
        end
      end
      if (wb_valid && hold_set) begin
        check("wb_hold", 32'({wb_q, wb_en, wb_skip, wb_ill}), 32'(hold_val));
      end
      hold_set = 1'b0;
      if (wb_valid && !wb_ready) begin
        hold_set = 1'b1;
        hold_val = {wb_q, wb_en, wb_skip, wb_ill};
      end
      if (wb_valid && wb_ready && sb.size() != 0) begin
        vec_t e;
        e = sb.pop_front();
        check("alu_op_held", 32'(alu_op), 32'(e.op));
        if (e.chk_q)    check("wb_q", 32'(wb_q), 32'(e.q));
        if (e.chk_exin) check("alu_exin", 32'(alu_exin), 32'(e.exin));
        check("wb_en",   32'(wb_en),   32'(e.en));
        check("wb_skip", 32'(wb_skip), 32'(e.skip));
        check("wb_ill",  32'(wb_ill),  32'(e.ill));
        ex_pend = 1'b1;
        ex_exp  = e.ex;
      end
      prev_vld = wb_valid;
    end
  end

  // Drive an op and hold in_valid until an edge where in_ready was high.
  task automatic issue(input vec_t v, input bit track);
    bit ok;
    ok = 1'b0;
    if (track) sb.push_back(v);
    in_op = v.op; in_b = v.b; in_a = v.a; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("issue_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    if (track && ok) acc_q.push_back(cyc);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'h0);
    @(posedge clk); @(posedge clk); #1;
  endtask

  task automatic wait_wb_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (wb_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check("wb_valid_timeout", 32'h0, 32'h1);
  endtask

  function automatic vec_t mk(input logic [4:0] op, input logic [15:0] b, input logic [15:0] a,
                              input logic [15:0] q, input logic chk_q, input logic en,
                              input logic skip, input logic ill, input logic [15:0] exv,
                              input logic chk_exin, input logic [15:0] exin, input int lat);
    vec_t v;
    v.op = op; v.b = b; v.a = a; v.q = q; v.chk_q = chk_q; v.en = en; v.skip = skip;
    v.ill = ill; v.ex = exv; v.chk_exin = chk_exin; v.exin = exin; v.lat = lat;
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    // op,   b,       a,       q,      cq, en, sk, il, ex after, cx, exin,  latency
    tbl[0]  = mk(5'h02, 16'hFFFF, 16'h0002, 16'h0001, 1, 1, 0, 0, 16'h0001, 0, 16'h0, 1);
    tbl[1]  = mk(5'h1A, 16'h0001, 16'h0001, 16'h0003, 1, 1, 0, 0, 16'h0000, 1, 16'h0001, 1);
    tbl[2]  = mk(5'h12, 16'h0005, 16'h0005, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 16'h0, 1);
    tbl[3]  = mk(5'h12, 16'h0005, 16'h0006, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 16'h0, 1);
    tbl[4]  = mk(5'h03, 16'h0003, 16'h0005, 16'hFFFE, 1, 1, 0, 0, 16'hFFFF, 0, 16'h0, 1);
    tbl[5]  = mk(5'h04, 16'h0100, 16'h0100, 16'h0000, 1, 1, 0, 0, 16'h0001, 0, 16'h0, 1 + LAT);
    tbl[6]  = mk(5'h0A, 16'hF0F0, 16'h0FF0, 16'h00F0, 1, 1, 0, 0, 16'h0001, 0, 16'h0, 1);
    tbl[7]  = mk(5'h10, 16'h0F00, 16'h00F0, 16'h0000, 0, 0, 1, 0, 16'h0001, 0, 16'h0, 1);
    tbl[8]  = mk(5'h14, 16'h0005, 16'h0003, 16'h0000, 0, 0, 0, 0, 16'h0001, 0, 16'h0, 1);
    tbl[9]  = mk(5'h17, 16'h8000, 16'h0001, 16'h0000, 0, 0, 0, 0, 16'h0001, 0, 16'h0, 1);
    tbl[10] = mk(5'h16, 16'h8000, 16'h0001, 16'h0000, 0, 0, 1, 0, 16'h0001, 0, 16'h0, 1);
    tbl[11] = mk(5'h18, 16'h1234, 16'h5678, 16'h0000, 0, 0, 0, 1, 16'h0001, 0, 16'h0, 1);
    tbl[12] = mk(5'h0F, 16'h8001, 16'h0001, 16'h0002, 1, 1, 0, 0, 16'h0001, 0, 16'h0, 1);
    tbl[13] = mk(5'h08, 16'h0007, 16'h0002, 16'h0001, 1, 1, 0, 0, 16'h0001, 0, 16'h0, 1 + LAT);

    // Reset state.
    #22;
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_wb_valid", 32'(wb_valid), 32'h0);
    check("rst_wb_flags", 32'({wb_q, wb_en, wb_skip, wb_ill}), 32'h0);
    check("rst_ex", 32'(ex), 32'h0);
    check("rst_alu_ops", 32'({alu_op, alu_b, alu_a} != 37'h0), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table, back-to-back with wb_ready high.
    wb_ready = 1'b1;
    foreach (tbl[i]) issue(tbl[i], 1'b1);
    wait_drain();

    // DIV with writeback stalled three cycles.
    wb_ready = 1'b0;
    issue(mk(5'h06, 16'h0007, 16'h0002, 16'h0003, 1, 1, 0, 0, 16'h8000, 0, 16'h0, 1 + LAT), 1'b1);
    wait_wb_valid();
    repeat (3) @(posedge clk);
    #1 wb_ready = 1'b1;
    wait_drain();

    // Commit and direct EX write on the same edge: the direct write wins.
    wb_ready = 1'b0;
    issue(mk(5'h02, 16'h0001, 16'h0001, 16'h0002, 1, 1, 0, 0, 16'h1234, 0, 16'h0, 1), 1'b1);
    wait_wb_valid();
    wb_ready = 1'b1; ex_set_valid = 1'b1; ex_set_data = 16'h1234;
    @(posedge clk); #1;
    ex_set_valid = 1'b0;
    wait_drain();

    // Reset in the middle of a DIV.
    issue(mk(5'h06, 16'h0009, 16'h0003, 16'h0, 0, 1, 0, 0, 16'h0, 0, 16'h0, 1 + LAT), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_wb_valid", 32'(wb_valid), 32'h0);
    check("midrst_ex", 32'(ex), 32'h0);
    acc_q.delete();
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_in_ready", 32'(in_ready), 32'h1);
    check("postrst_wb_valid", 32'(wb_valid), 32'h0);

    // Normal operation resumes after reset.
    issue(mk(5'h02, 16'h0001, 16'h0002, 16'h0003, 1, 1, 0, 0, 16'h0000, 1, 16'h0000, 1), 1'b1);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
